sequence_generator: RTL and testbench



---
 rtl/sequence_generator.sv | 168 ++++++++++++++++
 tb/tb_sequence_generator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// sequence_generator
//   Fills a 32x4 sequence RAM with pseudo-random digits on GoGen, then pulses
//   FinGen. The digit range is selected by Diff, which is latched when GoGen
//   is accepted. A free-running 16-bit Galois LFSR supplies the digits.
//   Reads are registered with a fixed 2-cycle latency (SeqAddr -> RAMOutput).
//   Optional build macro: SEQGEN_NOREPEAT_EN. When it is defined, a digit
//   that equals the previous digit of the same fill is bumped to the next
//   value in range.
module sequence_generator #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 4,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              GoGen,
   input  logic [1:0]        Diff,
   input  logic [ADDR_W-1:0] SeqAddr,
   output logic [DATA_W-1:0] RAMOutput,
   output logic              FinGen,
   output logic              GenBusy
);

   typedef enum logic {S_IDLE, S_GEN} state_t;

   state_t            r_state, w_state_nxt;
   logic [15:0]       r_lfsr, w_lfsr_nxt;
   logic [1:0]        r_diff, w_diff_nxt;
   logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
   logic              r_fin, w_fin_nxt;
   logic              r_busy, w_busy_nxt;
   logic              w_wr_en;
   logic              w_last;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_rd_data;

   logic [3:0]        w_raw;
   logic [3:0]        w_mapped;
   logic [3:0]        w_digit;

   assign w_raw     = r_lfsr[3:0];
   assign w_last    = (r_wr_ptr == ADDR_W'(DEPTH - 1));
   assign FinGen    = r_fin;
   assign GenBusy   = r_busy;
   assign RAMOutput = r_rd_data;

   // LFSR next value (Galois, mask 16'hB400)
   always_comb begin
      w_lfsr_nxt = r_lfsr >> 1;
      if (r_lfsr[0]) begin
         w_lfsr_nxt = (r_lfsr >> 1) ^ 16'hB400;
      end
   end

   // Map the raw LFSR nibble to a digit in the range chosen by the latched Diff
   always_comb begin
      w_mapped = {2'b00, w_raw[1:0]} + 4'd1;
      case (r_diff)
         2'b10:   w_mapped = {1'b0, w_raw[2:0]} + 4'd1;
         2'b11:   w_mapped = (w_raw <= 4'd9) ? w_raw : (w_raw - 4'd6);
         default: w_mapped = {2'b00, w_raw[1:0]} + 4'd1;
      endcase
   end

`ifdef SEQGEN_NOREPEAT_EN
   logic [3:0] r_prev;
   logic [3:0] w_bumped;

   // Next value in range with wrap-around; swap it in for an adjacent repeat (entry 0 untouched)
   always_comb begin
      w_bumped = w_mapped + 4'd1;
      case (r_diff)
         2'b10:   if (w_mapped == 4'd8) w_bumped = 4'd1;
         2'b11:   if (w_mapped == 4'd9) w_bumped = 4'd0;
         default: if (w_mapped == 4'd4) w_bumped = 4'd1;
      endcase
      w_digit = w_mapped;
      if ((r_wr_ptr != '0) && (w_mapped == r_prev)) begin
         w_digit = w_bumped;
      end
   end

   // Remember the last digit written in this fill
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_prev <= '0;
      end else if (w_wr_en) begin
         r_prev <= w_digit;
      end
   end
`else
   // Digits are used unmodified
   always_comb begin
      w_digit = w_mapped;
   end
`endif

   // FSM next-state and output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_diff_nxt   = r_diff;
      w_wr_ptr_nxt = r_wr_ptr;
      w_busy_nxt   = r_busy;
      w_fin_nxt    = 1'b0;
      w_wr_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (GoGen) begin
               w_state_nxt  = S_GEN;
               w_diff_nxt   = Diff;
               w_wr_ptr_nxt = '0;
               w_busy_nxt   = 1'b1;
            end
         end
         S_GEN: begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
            if (w_last) begin
               w_fin_nxt   = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, control and LFSR registers
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_state  <= S_IDLE;
         r_diff   <= '0;
         r_wr_ptr <= '0;
         r_fin    <= 1'b0;
         r_busy   <= 1'b0;
         r_lfsr   <= SEED;
      end else begin
         r_state  <= w_state_nxt;
         r_diff   <= w_diff_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_fin    <= w_fin_nxt;
         r_busy   <= w_busy_nxt;
         r_lfsr   <= w_lfsr_nxt;
      end
   end

   // Sequence RAM write port; contents survive reset
   always_ff @(posedge Clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= DATA_W'(w_digit);
      end
   end

   // Two-stage registered read: address capture, then data capture
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_addr_q  <= '0;
         r_rd_data <= '0;
      end else begin
         r_addr_q  <= SeqAddr;
         r_rd_data <= r_mem[r_addr_q];
      end
   end

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator
//   Self-checking bench for sequence_generator. A reference model tracks the
//   LFSR, precomputes each whole fill from the spec's digit rules, and holds a
//   shadow copy of the RAM for read checks.
`timescale 1ns/1ps
module tb_sequence_generator;

   localparam int unsigned DEPTH = 32;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic       Clk   = 1'b0;
   logic       Rst   = 1'b0;
   logic       GoGen = 1'b0;
   logic [1:0] Diff  = 2'b00;
   logic [4:0] SeqAddr = 5'd0;
   logic [3:0] RAMOutput;
   logic       FinGen;
   logic       GenBusy;

   sequence_generator #(
      .DEPTH  (32),
      .ADDR_W (5),
      .DATA_W (4),
      .SEED   (SEED)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .GoGen     (GoGen),
      .Diff      (Diff),
      .SeqAddr   (SeqAddr),
      .RAMOutput (RAMOutput),
      .FinGen    (FinGen),
      .GenBusy   (GenBusy)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   logic [15:0]      m_lfsr = SEED;
   logic [3:0]       m_mem  [DEPTH];
   logic [DEPTH-1:0] m_valid = '0;
   logic [3:0]       m_plan [DEPTH];
   int               m_left = 0;
   int               m_ptr  = 0;
   logic [4:0]       m_aq   = '0;
   logic [3:0]       m_rd   = '0;
   logic             m_rd_valid = 1'b0;
   logic             m_fin  = 1'b0;
   logic             m_busy = 1'b0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic int lo_of(input logic [1:0] d);
      return (d == 2'b11) ? 0 : 1;
   endfunction

   function automatic int hi_of(input logic [1:0] d);
      return (d == 2'b11) ? 9 : ((d == 2'b10) ? 8 : 4);
   endfunction

   function automatic int digit_of(input int raw, input logic [1:0] d);
      if (d == 2'b11) return (raw <= 9) ? raw : raw - 6;
      if (d == 2'b10) return (raw % 8) + 1;
      return (raw % 4) + 1;
   endfunction

   // Precompute all 32 digits of a fill from the LFSR value seen in the first write cycle
   task automatic plan_fill(input logic [15:0] start, input logic [1:0] d);
      logic [15:0] v;
      int dg;
      int prev;
      v    = start;
      prev = -1;
      for (int j = 0; j < int'(DEPTH); j++) begin
         dg = digit_of(int'(v[3:0]), d);
`ifdef SEQGEN_NOREPEAT_EN
         if (j > 0 && dg == prev) dg = (dg == hi_of(d)) ? lo_of(d) : dg + 1;
`endif
         m_plan[j] = 4'(dg);
         prev      = dg;
         v         = lfsr_next(v);
      end
   endtask

   always @(posedge Clk) begin
      if (!Rst) begin
         m_lfsr     = SEED;
         m_left     = 0;
         m_fin      = 1'b0;
         m_busy     = 1'b0;
         m_aq       = '0;
         m_rd       = '0;
         m_rd_valid = 1'b1;
      end else begin
         m_lfsr     = lfsr_next(m_lfsr);
         m_rd       = m_mem[m_aq];
         m_rd_valid = m_valid[m_aq];
         m_aq       = SeqAddr;
         m_fin      = 1'b0;
         if (m_left > 0) begin
            m_mem[m_ptr]   = m_plan[m_ptr];
            m_valid[m_ptr] = 1'b1;
            m_ptr++;
            m_left--;
            if (m_left == 0) begin
               m_fin  = 1'b1;
               m_busy = 1'b0;
            end
         end else if (GoGen) begin
            plan_fill(m_lfsr, Diff);
            m_left = DEPTH;
            m_ptr  = 0;
            m_busy = 1'b1;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare all outputs with the model
   task automatic cyc();
      @(negedge Clk);
      chk("FinGen", int'(FinGen), int'(m_fin));
      chk("GenBusy", int'(GenBusy), int'(m_busy));
      if (m_rd_valid) chk("RAMOutput", int'(RAMOutput), int'(m_rd));
   endtask

   // Run one fill; optionally re-pulse GoGen or assert reset at edge k+N (N<0 disables)
   task automatic fill(input logic [1:0] d, input int repulse_at, input int rst_at);
      int fin_n;
      int fin_cnt;
      int busy_cnt;
      fin_n    = -1;
      fin_cnt  = 0;
      busy_cnt = 0;
      Diff  = d;
      GoGen = 1'b1;
      cyc();
      GoGen = 1'b0;
      Diff  = 2'($urandom);
      for (int n = 0; n < 40; n++) begin
         if (GenBusy) busy_cnt++;
         if (FinGen) begin
            fin_cnt++;
            fin_n = n;
         end
         if (rst_at >= 0 && n == rst_at) chk("busy_after_rst", int'(GenBusy), 0);
         GoGen   = (n == repulse_at - 1);
         Rst     = !(n == rst_at - 1);
         SeqAddr = 5'($urandom);
         cyc();
      end
      GoGen = 1'b0;
      Rst   = 1'b1;
      if (rst_at >= 0) begin
         chk("fin_after_rst", fin_cnt, 0);
      end else begin
         chk("busy_cycles", busy_cnt, 32);
         chk("fin_count", fin_cnt, 1);
         chk("fin_edge", fin_n, 32);
      end
   endtask

   // Read back every entry; RAMOutput is checked against the model in cyc()
   task automatic readall(input logic [1:0] d, input bit do_range);
      int prev;
      int v;
      prev = -1;
      for (int a = 0; a < int'(DEPTH); a++) begin
         SeqAddr = 5'(a);
         cyc();
         cyc();
         v = int'(RAMOutput);
         if (do_range) begin
            chk("range_lo", int'(v >= lo_of(d)), 1);
            chk("range_hi", int'(v <= hi_of(d)), 1);
`ifdef SEQGEN_NOREPEAT_EN
            if (a > 0) chk("norepeat", int'(v == prev), 0);
`endif
         end
         prev = v;
      end
   endtask

   typedef struct {
      logic [1:0] diff;
      int         lo;
      int         hi;
   } vec_t;

   vec_t tbl [4];
   int   n;

   initial begin
      tbl[0] = '{diff: 2'b01, lo: 1, hi: 4};
      tbl[1] = '{diff: 2'b11, lo: 0, hi: 9};
      tbl[2] = '{diff: 2'b10, lo: 1, hi: 8};
      tbl[3] = '{diff: 2'b00, lo: 1, hi: 4};

      // reset
      Rst = 1'b0;
      cyc();
      cyc();
      chk("rst_fin", int'(FinGen), 0);
      chk("rst_busy", int'(GenBusy), 0);
      chk("rst_rd", int'(RAMOutput), 0);
      Rst = 1'b1;
      repeat (5) cyc();
      chk("idle_fin", int'(FinGen), 0);
      chk("idle_busy", int'(GenBusy), 0);

      // table-driven fills with range checks
      for (int i = 0; i < 4; i++) begin
         fill(tbl[i].diff, -1, -1);
         readall(tbl[i].diff, 1'b1);
         chk("tbl_lo_matches", lo_of(tbl[i].diff), tbl[i].lo);
      end

      // read timing: addr 5 then 6
      SeqAddr = 5'd5;
      cyc();
      SeqAddr = 5'd6;
      cyc();
      chk("rd_timing_5", int'(RAMOutput), int'(m_mem[5]));
      cyc();
      chk("rd_timing_6", int'(RAMOutput), int'(m_mem[6]));

      // GoGen re-pulsed mid-fill is ignored
      fill(2'b01, 10, -1);
      readall(2'b01, 1'b1);

      // reset mid-fill: no FinGen, then a normal fill afterwards
      fill(2'b11, -1, 15);
      fill(2'b10, -1, -1);
      readall(2'b10, 1'b1);

      // GoGen while FinGen is high is accepted at once
      Diff  = 2'b10;
      GoGen = 1'b1;
      cyc();
      GoGen = 1'b0;
      n = 0;
      while (!FinGen && n < 40) begin
         cyc();
         n++;
      end
      chk("chain_fin_seen", int'(FinGen), 1);
      Diff  = 2'b11;
      GoGen = 1'b1;
      cyc();
      GoGen = 1'b0;
      chk("chain_busy", int'(GenBusy), 1);
      repeat (40) cyc();
      readall(2'b11, 1'b1);

      // randomized fills with random idle gaps
      for (int r = 0; r < 10; r++) begin
         repeat ($urandom_range(1, 7)) begin
            SeqAddr = 5'($urandom);
            cyc();
         end
         n = int'($urandom_range(0, 3));
         fill(2'(n), -1, -1);
         readall(2'(n), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
